// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters.
// Round-robin grant, registered operands, one EXEC cycle, held response.
module alu_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid_in,
  input  logic          req1_valid_in,
  output logic          req0_ready_out,
  output logic          req1_ready_out,
  input  logic [DW-1:0] req0_A_in,
  input  logic [DW-1:0] req1_A_in,
  input  logic [DW-1:0] req0_B_in,
  input  logic [DW-1:0] req1_B_in,
  input  logic [5:0]    req0_aluop_in,
  input  logic [5:0]    req1_aluop_in,
  input  logic [4:0]    req0_shamt_in,
  input  logic [4:0]    req1_shamt_in,
  output logic          rsp0_valid_out,
  output logic          rsp1_valid_out,
  input  logic          rsp0_ready_in,
  input  logic          rsp1_ready_in,
  output logic [DW-1:0] rsp_result_out,
  output logic          rsp_zero_out,
  output logic          rsp_overflow_out,
  output logic [DW-1:0] alu_A_out,
  output logic [DW-1:0] alu_B_out,
  output logic [5:0]    alu_aluop_out,
  output logic [4:0]    alu_shamt_out,
  input  logic [DW-1:0] alu_result_in,
  input  logic          alu_zero_in,
  input  logic          alu_overflow_in,
  output logic          busy_out
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t        state;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [5:0]    op_q;
  logic [4:0]    sh_q;
  logic [DW-1:0] res_q;
  logic          zero_q;
  logic          ovf_q;
  logic          owner;
  logic          last_grant;
  logic          v0_q;
  logic          v1_q;
  logic          busy_q;
  logic          gnt0;
  logic          gnt1;
  logic          rsp_hs;

  // Round-robin pick: a lone requester wins, a tie goes to the other one.
  always_comb begin
    gnt0 = req0_valid_in & (~req1_valid_in | last_grant);
    gnt1 = req1_valid_in & (~req0_valid_in | ~last_grant);
  end

  assign req0_ready_out = rst_n & (state == IDLE) & gnt0;
  assign req1_ready_out = rst_n & (state == IDLE) & gnt1;

  assign rsp_hs = owner ? (v1_q & rsp1_ready_in)
                        : (v0_q & rsp0_ready_in);

  assign alu_A_out        = a_q;
  assign alu_B_out        = b_q;
  assign alu_aluop_out    = op_q;
  assign alu_shamt_out    = sh_q;
  assign rsp_result_out   = res_q;
  assign rsp_zero_out     = zero_q;
  assign rsp_overflow_out = ovf_q;
  assign rsp0_valid_out   = v0_q;
  assign rsp1_valid_out   = v1_q;
  assign busy_out         = busy_q;

  // Control FSM with operand, result and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      sh_q       <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0_ready_out | req1_ready_out) begin
            a_q        <= req1_ready_out ? req1_A_in : req0_A_in;
            b_q        <= req1_ready_out ? req1_B_in : req0_B_in;
            op_q       <= req1_ready_out ? req1_aluop_in
                                         : req0_aluop_in;
            sh_q       <= req1_ready_out ? req1_shamt_in
                                         : req0_shamt_in;
            owner      <= req1_ready_out;
            last_grant <= req1_ready_out;
            busy_q     <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          res_q  <= alu_result_in;
          zero_q <= alu_zero_in;
          ovf_q  <= alu_overflow_in;
          v0_q   <= ~owner;
          v1_q   <= owner;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter.
// Includes a behavioural ALU on the alu_* side.
module tb_alu_arbiter;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_SLL = 6'h00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid_in, req1_valid_in;
  logic        req0_ready_out, req1_ready_out;
  logic [31:0] req0_A_in, req1_A_in, req0_B_in, req1_B_in;
  logic [5:0]  req0_aluop_in, req1_aluop_in;
  logic [4:0]  req0_shamt_in, req1_shamt_in;
  logic        rsp0_valid_out, rsp1_valid_out;
  logic        rsp0_ready_in, rsp1_ready_in;
  logic [31:0] rsp_result_out;
  logic        rsp_zero_out, rsp_overflow_out;
  logic [31:0] alu_A_out, alu_B_out;
  logic [5:0]  alu_aluop_out;
  logic [4:0]  alu_shamt_out;
  logic [31:0] alu_result_in;
  logic        alu_zero_in, alu_overflow_in;
  logic        busy_out;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  op;
    logic [4:0]  sh;
    logic [31:0] er;
    logic        ez;
    logic        eo;
  } req_t;

  typedef struct {
    int          port;
    logic [31:0] r;
    logic        z;
    logic        o;
  } exp_t;

  req_t rq0[$];
  req_t rq1[$];
  exp_t sb[$];
  int   grants[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   hs_cyc = -10;
  bit   seen = 1'b1;

  alu_arbiter #(.DW(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req0_valid_in    (req0_valid_in),
    .req1_valid_in    (req1_valid_in),
    .req0_ready_out   (req0_ready_out),
    .req1_ready_out   (req1_ready_out),
    .req0_A_in        (req0_A_in),
    .req1_A_in        (req1_A_in),
    .req0_B_in        (req0_B_in),
    .req1_B_in        (req1_B_in),
    .req0_aluop_in    (req0_aluop_in),
    .req1_aluop_in    (req1_aluop_in),
    .req0_shamt_in    (req0_shamt_in),
    .req1_shamt_in    (req1_shamt_in),
    .rsp0_valid_out   (rsp0_valid_out),
    .rsp1_valid_out   (rsp1_valid_out),
    .rsp0_ready_in    (rsp0_ready_in),
    .rsp1_ready_in    (rsp1_ready_in),
    .rsp_result_out   (rsp_result_out),
    .rsp_zero_out     (rsp_zero_out),
    .rsp_overflow_out (rsp_overflow_out),
    .alu_A_out        (alu_A_out),
    .alu_B_out        (alu_B_out),
    .alu_aluop_out    (alu_aluop_out),
    .alu_shamt_out    (alu_shamt_out),
    .alu_result_in    (alu_result_in),
    .alu_zero_in      (alu_zero_in),
    .alu_overflow_in  (alu_overflow_in),
    .busy_out         (busy_out)
  );

  always #5 clk = ~clk;

  // Behavioural ALU fed from the arbiter's operand registers.
  always_comb begin
    alu_result_in   = alu_A_out & alu_B_out;
    alu_overflow_in = 1'b0;
    case (alu_aluop_out)
      OP_ADD: begin
        alu_result_in   = alu_A_out + alu_B_out;
        alu_overflow_in = (alu_A_out[31] == alu_B_out[31]) &&
                          (alu_result_in[31] != alu_A_out[31]);
      end
      OP_SUB: begin
        alu_result_in   = alu_A_out - alu_B_out;
        alu_overflow_in = (alu_A_out[31] != alu_B_out[31]) &&
                          (alu_result_in[31] != alu_A_out[31]);
      end
      OP_SLL: alu_result_in = alu_B_out << alu_shamt_out;
      default: ;
    endcase
    alu_zero_in = (alu_result_in == 32'h0);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic req_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [5:0] op, input logic [4:0] sh,
                              input logic [31:0] er, input logic ez,
                              input logic eo);
    req_t r;
    r.a = a; r.b = b; r.op = op; r.sh = sh;
    r.er = er; r.ez = ez; r.eo = eo;
    return r;
  endfunction

  // Request driver: presents each queue head until it is accepted.
  initial begin
    req0_valid_in = 1'b0; req1_valid_in = 1'b0;
    req0_A_in = '0; req0_B_in = '0; req0_aluop_in = '0; req0_shamt_in = '0;
    req1_A_in = '0; req1_B_in = '0; req1_aluop_in = '0; req1_shamt_in = '0;
    forever begin
      @(posedge clk);
      #2;
      req0_valid_in = (rq0.size() > 0);
      if (rq0.size() > 0) begin
        req0_A_in = rq0[0].a; req0_B_in = rq0[0].b;
        req0_aluop_in = rq0[0].op; req0_shamt_in = rq0[0].sh;
      end
      req1_valid_in = (rq1.size() > 0);
      if (rq1.size() > 0) begin
        req1_A_in = rq1[0].a; req1_B_in = rq1[0].b;
        req1_aluop_in = rq1[0].op; req1_shamt_in = rq1[0].sh;
      end
    end
  end

  // Monitor: records accepted requests, compares responses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (cyc == hs_cyc + 1)
          check("ready_pulse", {31'b0, req0_ready_out | req1_ready_out}, 0);
        if (!seen && (rsp0_valid_out || rsp1_valid_out)) begin
          seen = 1'b1;
          check("latency", cyc - hs_cyc, 2);
        end
        if (rsp0_valid_out && rsp1_valid_out)
          check("rsp_both", 1, 0);
        if ((rsp0_valid_out && rsp0_ready_in) ||
            (rsp1_valid_out && rsp1_ready_in)) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            e = sb.pop_front();
            check("rsp_port", rsp1_valid_out ? 1 : 0, e.port);
            check("result", rsp_result_out, e.r);
            check("zero", {31'b0, rsp_zero_out}, {31'b0, e.z});
            check("ovf", {31'b0, rsp_overflow_out}, {31'b0, e.o});
          end
        end
        if (req0_ready_out && req1_ready_out)
          check("grant_both", 1, 0);
        if (req0_valid_in && req0_ready_out && rq0.size() > 0) begin
          sb.push_back('{0, rq0[0].er, rq0[0].ez, rq0[0].eo});
          void'(rq0.pop_front());
          grants.push_back(0);
          hs_cyc = cyc; seen = 1'b0;
        end else if (req1_valid_in && req1_ready_out && rq1.size() > 0) begin
          sb.push_back('{1, rq1[0].er, rq1[0].ez, rq1[0].eo});
          void'(rq1.pop_front());
          grants.push_back(1);
          hs_cyc = cyc; seen = 1'b0;
        end
      end
    end
  end

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (rq0.size() == 0) && (rq1.size() == 0) &&
             (sb.size() == 0) && !busy_out;
    end
    check("drain", {31'b0, done}, 1);
  endtask

  task automatic wait_exec();
    bit hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = busy_out && !rsp0_valid_out && !rsp1_valid_out;
    end
    check("exec_seen", {31'b0, hit}, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0;
    rsp0_ready_in = 1'b1;
    rsp1_ready_in = 1'b1;
    rq0.push_back(mk(32'd5, 32'd7, OP_ADD, 5'd0, 32'd12, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy_out}, 0);
    check("rst_ready0", {31'b0, req0_ready_out}, 0);
    check("rst_rsp0", {31'b0, rsp0_valid_out}, 0);
    check("rst_alu_a", alu_A_out, 0);
    check("rst_result", rsp_result_out, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    drain();

    do_reset();
    grants.delete();
    rq0.push_back(mk(32'd1, 32'd2, OP_ADD, 5'd0, 32'd3, 1'b0, 1'b0));
    rq0.push_back(mk(32'd10, 32'd20, OP_ADD, 5'd0, 32'd30, 1'b0, 1'b0));
    rq1.push_back(mk(32'd9, 32'd4, OP_SUB, 5'd0, 32'd5, 1'b0, 1'b0));
    rq1.push_back(mk(32'd100, 32'd1, OP_SUB, 5'd0, 32'd99, 1'b0, 1'b0));
    drain();
    check("rr_count", grants.size(), 4);
    if (grants.size() == 4) begin
      check("rr_g0", grants[0], 0);
      check("rr_g1", grants[1], 1);
      check("rr_g2", grants[2], 0);
      check("rr_g3", grants[3], 1);
    end

    @(posedge clk); #2;
    rsp1_ready_in = 1'b0;
    rq1.push_back(mk(32'd3, 32'd4, OP_ADD, 5'd0, 32'd7, 1'b0, 1'b0));
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = rsp1_valid_out;
    end
    check("bp_valid_seen", {31'b0, hit}, 1);
    rq0.push_back(mk(32'd1, 32'd1, OP_ADD, 5'd0, 32'd2, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, rsp1_valid_out}, 1);
      check("bp_result", rsp_result_out, 32'd7);
      check("bp_ready", {30'b0, req1_ready_out, req0_ready_out}, 0);
    end
    @(posedge clk); #2;
    rsp1_ready_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_done", {31'b0, rsp1_valid_out}, 0);
    check("bp_next_ready", {31'b0, req0_ready_out}, 1);
    drain();

    rq0.push_back(mk(32'h7FFFFFFF, 32'h1, OP_ADD, 5'd0,
                     32'h80000000, 1'b0, 1'b1));
    rq1.push_back(mk(32'h1234, 32'h1234, OP_SUB, 5'd0, 32'h0, 1'b1, 1'b0));
    drain();

    rq0.push_back(mk(32'h0, 32'h1, OP_SLL, 5'd4, 32'h10, 1'b0, 1'b0));
    wait_exec();
    check("sll_shamt", {27'b0, alu_shamt_out}, 4);
    check("sll_op", {26'b0, alu_aluop_out}, {26'b0, OP_SLL});
    check("sll_b", alu_B_out, 1);
    drain();

    rq0.push_back(mk(32'd2, 32'd2, OP_ADD, 5'd0, 32'd4, 1'b0, 1'b0));
    wait_exec();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_busy", {31'b0, busy_out}, 0);
    check("mid_alu_a", alu_A_out, 0);
    check("mid_result", rsp_result_out, 0);
    sb.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hit = hit | rsp0_valid_out | rsp1_valid_out;
    end
    check("mid_no_rsp", {31'b0, hit}, 0);
    grants.delete();
    rq0.push_back(mk(32'd6, 32'd6, OP_ADD, 5'd0, 32'd12, 1'b0, 1'b0));
    rq1.push_back(mk(32'd6, 32'd6, OP_SUB, 5'd0, 32'd0, 1'b1, 1'b0));
    drain();
    check("mid_tie_count", grants.size(), 2);
    if (grants.size() > 0)
      check("mid_tie_g0", grants[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
